// File: rtl/bcd_conv_seq.sv
// bcd_conv_seq: iterative double-dabble binary-to-BCD converter.
// One shift-add-3 step per clock, valid/ready on both sides, plus a
// one-entry hold buffer so the producer can hand over the next value
// while the current conversion is still running.
//
// Handshake semantics (both ports): a transfer happens at a rising edge
// where valid && ready are both 1. A producer keeps valid and its data
// steady until the transfer. in_ready is a function of registered state
// only (hold buffer empty) and never looks at in_valid. out_valid and
// bcd_code are registers and stay frozen until the output transfer.
//
// DIGITS must be large enough that 10^DIGITS > 2^WIDTH-1; the default
// pair (12, 4) covers 0..4095.

module bcd_conv_seq #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      mult_result,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  // IDLE: nothing in flight. SHIFT: one double-dabble step per cycle.
  // DONE: result presented, waiting for the consumer.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  // {digit field, binary field}; the binary field drains into the digits.
  logic [SR_W-1:0]    r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hold;
  logic               r_hold_full;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_out_valid;

  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_last;
  logic               w_load;
  logic [WIDTH-1:0]   w_load_val;
  logic               w_hold_wr;
  logic               w_hold_clr;
  logic [SR_W-1:0]    w_adj;
  logic [SR_W-1:0]    w_step;

  // Handshake events and the final-shift marker.
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_last     = (r_state == S_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

  // A new conversion starts from IDLE on an input transfer, or from DONE
  // on an output transfer when either the hold buffer or the input port
  // can supply the next value (the latter avoids an IDLE bubble).
  always_comb begin
    w_load     = 1'b0;
    w_load_val = mult_result;
    if (r_state == S_IDLE) begin
      w_load = w_in_xfer;
    end else if (r_state == S_DONE && w_out_xfer) begin
      if (r_hold_full) begin
        w_load     = 1'b1;
        w_load_val = r_hold;
      end else begin
        w_load = w_in_xfer;
      end
    end
  end

  // The hold buffer captures inputs that arrive while a conversion owns
  // the shift register. In DONE with a simultaneous output transfer the
  // input goes straight into the shift register instead. Since in_ready
  // is low whenever the buffer is full, write and clear never coincide.
  always_comb begin
    w_hold_wr  = w_in_xfer &&
                 ((r_state == S_SHIFT) || (r_state == S_DONE && !w_out_xfer));
    w_hold_clr = (r_state == S_DONE) && w_out_xfer && r_hold_full;
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift left.
  always_comb begin
    w_adj = r_shift;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_shift[WIDTH + 4*d +: 4] >= 4'd5) begin
        w_adj[WIDTH + 4*d +: 4] = r_shift[WIDTH + 4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_step = w_adj << 1;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_in_xfer) begin
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (w_out_xfer) begin
          w_next_state = w_load ? S_SHIFT : S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // FSM outputs: status flags derived from registered state only.
  always_comb begin
    busy     = (r_state == S_SHIFT);
    in_ready = !r_hold_full;
  end

  // Shift register and iteration counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_shift <= {{BCD_W{1'b0}}, w_load_val};
      r_cnt   <= '0;
    end else if (r_state == S_SHIFT) begin
      r_shift <= w_step;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // One-entry hold buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_hold_wr) begin
      r_hold      <= mult_result;
      r_hold_full <= 1'b1;
    end else if (w_hold_clr) begin
      r_hold_full <= 1'b0;
    end
  end

  // Result register: written only on the final shift, when out_valid is
  // necessarily low, so bcd_code never moves while it is being offered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcd       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_last) begin
      r_bcd       <= w_step[SR_W-1 -: BCD_W];
      r_out_valid <= 1'b1;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bcd_code  = r_bcd;
  assign out_valid = r_out_valid;

endmodule

// File: doc/bcd_conv_seq.md
Name: bcd_conv_seq

Overview:
Iterative (double-dabble) binary-to-BCD conversion sequencer that sits between the multiplier result and the display path.
- Accepts a 12-bit product over a valid/ready handshake and runs one shift-add-3 step per clock.
- Presents packed BCD digits over a valid/ready handshake.
- A one-entry hold buffer lets the multiplier deliver the next product while a conversion is still running.

Parameters:
- WIDTH, 12, binary input width; conversion takes WIDTH shift cycles.
- DIGITS, 4, BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH-1; the default pair is legal, with max 4095.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mult_result  in  WIDTH  binary value to convert.
- in_valid  in  1  mult_result is valid.
- in_ready  out  1  block can accept mult_result this cycle.
- bcd_code  out  4*DIGITS  packed BCD result, most-significant digit in [4*DIGITS-1 -: 4].
- out_valid  out  1  bcd_code holds a completed conversion.
- out_ready  in  1  consumer takes bcd_code this cycle.
- busy  out  1  state is SHIFT.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; hold buffer is emptied.
  - bcd_code=0, out_valid=0, busy=0, in_ready=1.
  - Iteration counter and shift register go to 0.
  - Reset mid-conversion discards both the in-flight value and the held value; no out_valid follows.
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- in_ready = !hold_full (combinational from registered state only; no dependence on in_valid).
- States:
  - IDLE: on input transfer, load mult_result into the shift register with digit field=0, clear the counter, go to SHIFT.
  - SHIFT: each cycle, first add 3 to every digit >= 5, then shift the {digits, binary} register left by 1 and increment the counter. After the WIDTH-th shift, latch the digit field into bcd_code, set out_valid=1, go to DONE.
  - DONE: bcd_code and out_valid hold stable until an output transfer. On output transfer:
    - if hold_full: load the held value, clear hold_full, go to SHIFT;
    - else if in_valid: load mult_result directly (in_ready=1), go to SHIFT;
    - else: go to IDLE.
    - out_valid drops in the cycle after the transfer.
- Hold buffer:
  - An input transfer while in SHIFT or DONE writes the hold register and sets hold_full.
  - hold_full is never set while in IDLE.
  - Only one entry; further inputs are stalled by in_ready=0 and never lost.
- Latency: input accepted at edge N means out_valid=1 and bcd_code valid after edge N+WIDTH (12 SHIFT cycles).
- Throughput: one result per WIDTH+1 cycles when out_ready is held at 1.
- Simultaneous output transfer and input transfer in DONE with hold empty: the new value starts converting immediately; no IDLE bubble.
- bcd_code is never updated while out_valid=1.
- busy=1 exactly during SHIFT cycles.
- Values 0 and 2^WIDTH-1 need no special casing; the digit field never exceeds 9 per digit.

Test Plan:
- Reset, then mult_result=45 with a one-cycle in_valid and out_ready=1 -> out_valid rises exactly 12 cycles after acceptance, bcd_code=16'h0045.
- Conversions of 0, 123, 999, 2047, 4095 -> bcd_code = 16'h0000, 16'h0123, 16'h0999, 16'h2047, 16'h4095.
- out_ready=0 for 20 cycles after completing 256 -> bcd_code=16'h0256 and out_valid held stable the whole time.
- Hold buffer: submit 45, then submit 123 during SHIFT, then attempt 999 while hold_full -> in_ready=0 blocks 999. Outputs arrive in order 0045 then 0123, with no IDLE cycle between the two conversions.
- Streaming with in_valid and out_ready tied to 1 and incrementing inputs -> one result per 13 cycles, each correct.
- Assert reset at SHIFT cycle 6 of 999 with a held value pending -> all outputs return to reset values immediately. After release, no stale out_valid appears and the next input 77 gives 16'h0077.
